// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared cause codes, mip bit positions, privilege and FSM encodings
package irq_controller_pkg;
  localparam logic [4:0] IRQ_SSI = 5'd1, IRQ_MSI = 5'd3, IRQ_STI = 5'd5;
  localparam logic [4:0] IRQ_MTI = 5'd7, IRQ_SEI = 5'd9, IRQ_MEI = 5'd11;
  localparam int MIP_SSIP = 1, MIP_MSIP = 3, MIP_STIP = 5, MIP_MTIP = 7, MIP_SEIP = 9, MIP_MEIP = 11;
  localparam logic [1:0] PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_TAKE, ST_HOLD} state_t;
  function automatic logic [4:0] pick(input logic [31:0] p);
    return p[MIP_MEIP] ? IRQ_MEI : p[MIP_MSIP] ? IRQ_MSI : p[MIP_MTIP] ? IRQ_MTI :
           p[MIP_SEIP] ? IRQ_SEI : p[MIP_SSIP] ? IRQ_SSI : p[MIP_STIP] ? IRQ_STI : 5'd0;
  endfunction
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: drain handshake and take command between controller and pipeline/CSR file
interface irq_controller_if;
  logic drain_req;
  logic drain_ack;
  logic [31:0] epc_in;
  logic take;
  logic [4:0] take_cause;
  logic take_to_s;
  logic [31:0] take_epc;
  modport master(output drain_req, take, take_cause, take_to_s, take_epc, input drain_ack, epc_in);
  modport slave(input drain_req, take, take_cause, take_to_s, take_epc, output drain_ack, epc_in);
endinterface

// File: rtl/irq_priority_enc.sv
// irq_priority_enc: privilege/enable masking and fixed-priority interrupt selection
module irq_priority_enc
  import irq_controller_pkg::*;
(
  input  logic [31:0] pend,
  input  logic [31:0] mideleg,
  input  logic [1:0]  priv,
  input  logic        m_ie,
  input  logic        s_ie,
  output logic        any_irq,
  output logic [4:0]  sel_cause,
  output logic        sel_to_s
);
  logic [31:0] m_pend, s_pend;
  always_comb begin
    m_pend = pend & ~mideleg & {32{priv != PRIV_M || m_ie}};
    s_pend = pend & mideleg & {32{priv == PRIV_U || (priv == PRIV_S && s_ie)}};
    any_irq = (|m_pend) || (|s_pend);
    sel_to_s = !(|m_pend) && (|s_pend);
    sel_cause = (|m_pend) ? pick(m_pend) : pick(s_pend);
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: interrupt arbitration and drain/take trap-entry sequencer
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msip,
  input  logic        mtip,
  input  logic        meip,
  input  logic [2:0]  sw_pend,
  input  logic [31:0] mie,
  input  logic [31:0] mideleg,
  input  logic        mstatus_mie,
  input  logic        mstatus_sie,
  input  logic [1:0]  priv,
  input  logic        exc_pending,
  input  logic        trap_busy,
  irq_controller_if.master bus,
  output logic [31:0] mip_o
);
  localparam int CW = $clog2((DRAIN_TIMEOUT > HOLD_CYCLES ? DRAIN_TIMEOUT : HOLD_CYCLES) + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic drain_req_q, drain_req_d, take_q, take_d, to_s_q, to_s_d;
  logic [4:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic any_irq, sel_to_s;
  logic [4:0] sel_cause;
  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, meip});
    mip_o = '0;
    mip_o[MIP_SSIP] = sw_pend[0];
    mip_o[MIP_STIP] = sw_pend[1];
    mip_o[MIP_SEIP] = sw_pend[2];
    mip_o[MIP_MSIP] = msip;
    mip_o[MIP_MTIP] = mtip;
    mip_o[MIP_MEIP] = sync_q[SYNC_STAGES-1];
  end
  irq_priority_enc u_enc (
    .pend(mip_o & mie),
    .mideleg(mideleg),
    .priv(priv),
    .m_ie(mstatus_mie),
    .s_ie(mstatus_sie),
    .any_irq(any_irq),
    .sel_cause(sel_cause),
    .sel_to_s(sel_to_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    drain_req_d = 1'b0;
    take_d = 1'b0;
    cause_d = cause_q;
    to_s_d = to_s_q;
    epc_d = epc_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        state_d = (any_irq && !exc_pending && !trap_busy) ? ST_DRAIN : ST_IDLE;
        drain_req_d = state_d == ST_DRAIN;
      end
      ST_DRAIN: begin
        if (exc_pending || !any_irq || (!bus.drain_ack && cnt_q == CW'(DRAIN_TIMEOUT - 1))) begin
          state_d = ST_IDLE;
          cnt_d = '0;
        end else if (bus.drain_ack) begin
          state_d = ST_TAKE;
          cnt_d = '0;
          drain_req_d = 1'b1;
          take_d = 1'b1;
          cause_d = sel_cause;
          to_s_d = sel_to_s;
          epc_d = bus.epc_in;
        end else begin
          drain_req_d = 1'b1;
        end
      end
      ST_TAKE: begin
        state_d = ST_HOLD;
        cnt_d = '0;
      end
      default: begin
        state_d = cnt_q == CW'(HOLD_CYCLES - 1) ? ST_IDLE : ST_HOLD;
        cnt_d = state_d == ST_IDLE ? '0 : cnt_d;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sync_q <= '0;
      drain_req_q <= 1'b0;
      take_q <= 1'b0;
      cause_q <= '0;
      to_s_q <= 1'b0;
      epc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      drain_req_q <= drain_req_d;
      take_q <= take_d;
      cause_q <= cause_d;
      to_s_q <= to_s_d;
      epc_q <= epc_d;
    end
  end
  assign bus.drain_req = drain_req_q;
  assign bus.take = take_q;
  assign bus.take_cause = cause_q;
  assign bus.take_to_s = to_s_q;
  assign bus.take_epc = epc_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven and scoreboarded checks of the interrupt controller
module tb_irq_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic msip = 0, mtip = 0, meip = 0, mstatus_mie = 0, mstatus_sie = 0, exc_pending = 0, trap_busy = 0;
  logic [2:0] sw_pend = '0;
  logic [31:0] mie = '0, mideleg = '0, mip_o;
  logic [1:0] priv = 2'd3;
  int n_vec = 0, n_err = 0;
  irq_controller_if bus();
  irq_controller dut (
    .clk(clk), .rst(rst), .msip(msip), .mtip(mtip), .meip(meip), .sw_pend(sw_pend),
    .mie(mie), .mideleg(mideleg), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .priv(priv), .exc_pending(exc_pending), .trap_busy(trap_busy), .bus(bus), .mip_o(mip_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] priv; logic m_ie, s_ie; logic [31:0] ie, deleg;
    logic ms, mt; logic [2:0] sw; logic exp_take; logic [4:0] cause; logic to_s;
  } vec_t;
  typedef struct { logic [4:0] cause; logic to_s; logic [31:0] epc; } exp_t;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[11];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drain(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      step();
      ok = bus.drain_req;
    end
  endtask
  task automatic clear_inputs();
    {msip, mtip, meip, mstatus_mie, mstatus_sie, exc_pending, trap_busy} = '0;
    sw_pend = '0; mie = '0; mideleg = '0; priv = 2'd3; bus.drain_ack = 1'b0;
  endtask
  task automatic setup_mtip(input logic [31:0] epc);
    rst = 1'b1;
    clear_inputs();
    mstatus_mie = 1'b1; mie = 32'h80; mtip = 1'b1; bus.epc_in = epc;
    repeat (2) step();
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.take === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_take: got cause %0d expected no take", bus.take_cause);
      end else begin
        e = sb.pop_front();
        chk("take_cause", 32'(bus.take_cause), 32'(e.cause));
        chk("take_to_s", 32'(bus.take_to_s), 32'(e.to_s));
        chk("take_epc", bus.take_epc, e.epc);
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic ok, seen;
    int n;
    bus.drain_ack = 1'b0;
    bus.epc_in = '0;
    vecs[0]  = '{2'd3, 1, 0, 32'h080, 32'h000, 0, 1, 3'b000, 1, 5'd7, 0};
    vecs[1]  = '{2'd3, 1, 0, 32'h888, 32'h000, 1, 1, 3'b000, 1, 5'd3, 0};
    vecs[2]  = '{2'd0, 0, 0, 32'h020, 32'h020, 0, 0, 3'b010, 1, 5'd5, 1};
    vecs[3]  = '{2'd3, 1, 1, 32'h020, 32'h020, 0, 0, 3'b010, 0, 5'd0, 0};
    vecs[4]  = '{2'd3, 0, 0, 32'h080, 32'h000, 0, 1, 3'b000, 0, 5'd0, 0};
    vecs[5]  = '{2'd1, 0, 1, 32'h0A2, 32'h222, 0, 1, 3'b011, 1, 5'd7, 0};
    vecs[6]  = '{2'd1, 0, 1, 32'h222, 32'h222, 0, 0, 3'b111, 1, 5'd9, 1};
    vecs[7]  = '{2'd1, 0, 0, 32'h222, 32'h222, 0, 0, 3'b111, 0, 5'd0, 0};
    vecs[8]  = '{2'd0, 0, 0, 32'h022, 32'h222, 0, 0, 3'b011, 1, 5'd1, 1};
    vecs[9]  = '{2'd3, 1, 0, 32'h020, 32'h000, 0, 0, 3'b010, 1, 5'd5, 0};
    vecs[10] = '{2'd1, 0, 0, 32'h028, 32'h020, 1, 0, 3'b010, 1, 5'd3, 0};
    repeat (2) step();
    chk("rst_drain_req", 32'(bus.drain_req), 0);
    chk("rst_take", 32'(bus.take), 0);
    chk("rst_take_cause", 32'(bus.take_cause), 0);
    chk("rst_take_to_s", 32'(bus.take_to_s), 0);
    chk("rst_take_epc", bus.take_epc, 0);
    chk("rst_mip_o", mip_o, 0);
    foreach (vecs[i]) begin
      rst = 1'b1;
      clear_inputs();
      priv = vecs[i].priv; mstatus_mie = vecs[i].m_ie; mstatus_sie = vecs[i].s_ie;
      mie = vecs[i].ie; mideleg = vecs[i].deleg; msip = vecs[i].ms; mtip = vecs[i].mt;
      sw_pend = vecs[i].sw; bus.epc_in = 32'h8000_0040 + 32'(i * 16);
      repeat (2) step();
      rst = 1'b0;
      if (vecs[i].exp_take) begin
        wait_drain(ok);
        chk("vec_drain_seen", 32'(ok), 1);
        if (ok) begin
          repeat (2) step();
          sb.push_back('{vecs[i].cause, vecs[i].to_s, bus.epc_in});
          bus.drain_ack = 1'b1;
          step();
          bus.drain_ack = 1'b0;
          chk("vec_take_pulse", 32'(bus.take), 1);
          repeat (2) step();
          chk("vec_take_seen", sb.size(), 0);
        end
      end else begin
        seen = 1'b0;
        repeat (6) begin
          step();
          seen |= bus.drain_req;
        end
        chk("vec_no_drain", 32'(seen), 0);
      end
    end
    // meip raised mid-DRAIN wins after sync delay; then HOLD spacing before re-drain
    rst = 1'b1;
    clear_inputs();
    mstatus_mie = 1'b1; mie = 32'h888; mtip = 1'b1; bus.epc_in = 32'h8000_1000;
    repeat (2) step();
    rst = 1'b0;
    wait_drain(ok);
    chk("meip_drain_seen", 32'(ok), 1);
    meip = 1'b1;
    repeat (3) step();
    chk("mip_o_meip", mip_o, 32'h880);
    sb.push_back('{5'd11, 1'b0, 32'h8000_1000});
    bus.drain_ack = 1'b1;
    step();
    bus.drain_ack = 1'b0;
    chk("meip_take_pulse", 32'(bus.take), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_spacing", 32'(bus.drain_req), 32'(k == 3));
    end
    chk("meip_take_seen", sb.size(), 0);
    // trap_busy blocks entry; exc_pending in DRAIN aborts and later re-enters
    setup_mtip(32'h8000_2000);
    trap_busy = 1'b1;
    repeat (3) step();
    chk("busy_blocks", 32'(bus.drain_req), 0);
    trap_busy = 1'b0;
    step();
    chk("busy_release", 32'(bus.drain_req), 1);
    step();
    exc_pending = 1'b1;
    step();
    chk("exc_abort", 32'(bus.drain_req), 0);
    step();
    chk("exc_stay_idle", 32'(bus.drain_req), 0);
    exc_pending = 1'b0;
    step();
    chk("exc_reenter", 32'(bus.drain_req), 1);
    // drain timeout: exactly DRAIN_TIMEOUT cycles of drain_req, one idle, retry
    setup_mtip(32'h8000_3000);
    wait_drain(ok);
    n = 0;
    while (bus.drain_req && n < 40) begin
      n++;
      step();
    end
    chk("timeout_len", n, 16);
    step();
    chk("timeout_retry", 32'(bus.drain_req), 1);
    // reset pulsed during TAKE
    setup_mtip(32'h8000_4000);
    wait_drain(ok);
    sb.push_back('{5'd7, 1'b0, 32'h8000_4000});
    bus.drain_ack = 1'b1;
    step();
    bus.drain_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_take_take", 32'(bus.take), 0);
    chk("rst_take_drain", 32'(bus.drain_req), 0);
    chk("rst_take_cause_clr", 32'(bus.take_cause), 0);
    chk("rst_take_epc_clr", bus.take_epc, 0);
    chk("rst_take_seen", sb.size(), 0);
    // mtip withdrawn together with drain_ack: abort wins, no take
    setup_mtip(32'h8000_5000);
    wait_drain(ok);
    step();
    mtip = 1'b0;
    bus.drain_ack = 1'b1;
    step();
    bus.drain_ack = 1'b0;
    chk("withdraw_drain", 32'(bus.drain_req), 0);
    chk("withdraw_take", 32'(bus.take), 0);
    repeat (4) step();
    // full mip_o view with interrupts masked globally
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
    msip = 1'b1; mtip = 1'b1; meip = 1'b1; sw_pend = 3'b111; mie = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("mip_o_all", mip_o, 32'h0000_0AAA);
    chk("masked_no_drain", 32'(bus.drain_req), 0);
    chk("sb_empty_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
